// File: rtl/eq_serial_ctrl.sv
// Bit-serial equality comparator: one shared XNOR cell walks the operands LSB first
// and reports equal/not-equal plus the lowest differing bit index.
module eq_serial_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int IW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic [IW-1:0]    mismatch_idx,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [IW:0] CNT_LAST = (IW+1)'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [IW:0]      cnt_q, cnt_d;
  logic             eq_acc_q, eq_acc_d;
  logic [IW-1:0]    idx_acc_q, idx_acc_d;
  logic             stop_q, stop_d;
  logic             out_valid_q, out_valid_d;
  logic             eq_q, eq_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             bit_eq;

  // The single shared 1-bit equality cell.
  assign bit_eq = ~(sa_q[0] ^ sb_q[0]);

  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    eq_acc_d    = eq_acc_q;
    idx_acc_d   = idx_acc_q;
    stop_d      = stop_q;
    out_valid_d = out_valid_q;
    eq_d        = eq_q;
    idx_d       = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d      = a;
          sb_d      = b;
          cnt_d     = '0;
          eq_acc_d  = 1'b1;
          idx_acc_d = '0;
          stop_d    = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The terminal bit is processed one edge before DONE is entered.
        if (stop_q) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          eq_d        = eq_acc_q;
          idx_d       = idx_acc_q;
        end else begin
          sa_d  = sa_q >> 1;
          sb_d  = sb_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (!bit_eq && eq_acc_q) begin
            eq_acc_d  = 1'b0;
            idx_acc_d = cnt_q[IW-1:0];
          end
          if ((cnt_q == CNT_LAST) || (EARLY_EXIT && !bit_eq))
            stop_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      cnt_q       <= '0;
      eq_acc_q    <= 1'b0;
      idx_acc_q   <= '0;
      stop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      eq_acc_q    <= eq_acc_d;
      idx_acc_q   <= idx_acc_d;
      stop_q      <= stop_d;
      out_valid_q <= out_valid_d;
      eq_q        <= eq_d;
      idx_q       <= idx_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q == SHIFT);
  assign out_valid    = out_valid_q;
  assign eq           = eq_q;
  assign mismatch_idx = idx_q;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Directed bench: an EARLY_EXIT=1 and an EARLY_EXIT=0 instance share stimulus
// and are checked against hand-computed latencies and results.
module tb_eq_serial_ctrl;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready;
  logic [7:0] a, b;
  logic       in_ready_e, ov_e, eq_e, busy_e;
  logic       in_ready_f, ov_f, eq_f, busy_f;
  logic [2:0] idx_e, idx_f;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eq_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_e),
    .a(a), .b(b), .out_valid(ov_e), .out_ready(out_ready),
    .eq(eq_e), .mismatch_idx(idx_e), .busy(busy_e)
  );

  eq_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_f),
    .a(a), .b(b), .out_valid(ov_f), .out_ready(out_ready),
    .eq(eq_f), .mismatch_idx(idx_f), .busy(busy_f)
  );

  // Stimulus only: accept one pair, then count edges until each instance shows out_valid.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       output int lat_e, output int lat_f);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat_e = -1; lat_f = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ov_e && lat_e < 0) lat_e = n;
      if (ov_f && lat_f < 0) lat_f = n;
      if (lat_e >= 0 && lat_f >= 0) break;
    end
    $display("op a=%h b=%h lat_e=%0d eq_e=%0b idx_e=%0d lat_f=%0d eq_f=%0b idx_f=%0d",
             av, bv, lat_e, eq_e, idx_e, lat_f, eq_f, idx_f);
  endtask

  task automatic do_release();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({in_ready_e, ov_e, busy_e, eq_e, idx_e} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_e got=%b exp=%b", {in_ready_e, ov_e, busy_e, eq_e, idx_e}, 7'b1000000);
    end
    checks++;
    if ({in_ready_f, ov_f, busy_f, eq_f, idx_f} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_f got=%b exp=%b", {in_ready_f, ov_f, busy_f, eq_f, idx_f}, 7'b1000000);
    end
  endtask

  // Runs one pair and checks latency/eq/idx on both instances plus the release handshake.
  task automatic test_pair(input string name, input logic [7:0] av, input logic [7:0] bv,
                           input int xl_e, input logic xeq_e, input logic [2:0] xidx_e,
                           input int xl_f, input logic xeq_f, input logic [2:0] xidx_f);
    int le, lf;
    do_op(av, bv, le, lf);
    checks++;
    if (le !== xl_e || eq_e !== xeq_e || idx_e !== xidx_e) begin
      failures++;
      $display("FAIL %s_early got lat=%0d eq=%0b idx=%0d exp lat=%0d eq=%0b idx=%0d",
               name, le, eq_e, idx_e, xl_e, xeq_e, xidx_e);
    end
    checks++;
    if (lf !== xl_f || eq_f !== xeq_f || idx_f !== xidx_f) begin
      failures++;
      $display("FAIL %s_full got lat=%0d eq=%0b idx=%0d exp lat=%0d eq=%0b idx=%0d",
               name, lf, eq_f, idx_f, xl_f, xeq_f, xidx_f);
    end
    do_release();
    checks++;
    if ({ov_e, ov_f, in_ready_e, in_ready_f, eq_e, idx_e, eq_f, idx_f} !==
        {4'b0011, xeq_e, xidx_e, xeq_f, xidx_f}) begin
      failures++;
      $display("FAIL %s_release got=%b exp=%b", name,
               {ov_e, ov_f, in_ready_e, in_ready_f, eq_e, idx_e, eq_f, idx_f},
               {4'b0011, xeq_e, xidx_e, xeq_f, xidx_f});
    end
  endtask

  task automatic test_hold();
    int le, lf;
    do_op(8'h3C, 8'h34, le, lf);
    checks++;
    if (le !== 5 || lf !== 9) begin
      failures++;
      $display("FAIL hold_lat got e=%0d f=%0d exp e=5 f=9", le, lf);
    end
    a = 8'hFF; b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      checks++;
      if ({ov_e, in_ready_e, eq_e, idx_e, ov_f, in_ready_f, eq_f, idx_f} !== 12'b100011_100011) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%b exp=%b", i,
                 {ov_e, in_ready_e, eq_e, idx_e, ov_f, in_ready_f, eq_f, idx_f}, 12'b100011_100011);
      end
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({ov_e, in_ready_e, busy_e, ov_f, in_ready_f, busy_f} !== 6'b010_010) begin
      failures++;
      $display("FAIL hold_no_same_cycle_accept got=%b exp=%b",
               {ov_e, in_ready_e, busy_e, ov_f, in_ready_f, busy_f}, 6'b010_010);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({busy_e, busy_f} !== 2'b11) begin
      failures++;
      $display("FAIL hold_accept_after_idle got=%b exp=11", {busy_e, busy_f});
    end
    for (int n = 0; n < 40 && !(ov_e && ov_f); n++) begin
      @(posedge clk); #1;
    end
    $display("op a=ff b=00 eq_e=%0b idx_e=%0d eq_f=%0b idx_f=%0d", eq_e, idx_e, eq_f, idx_f);
    checks++;
    if ({ov_e, eq_e, idx_e, ov_f, eq_f, idx_f} !== 10'b10000_10000) begin
      failures++;
      $display("FAIL hold_second_result got=%b exp=%b",
               {ov_e, eq_e, idx_e, ov_f, eq_f, idx_f}, 10'b10000_10000);
    end
    do_release();
  endtask

  task automatic test_reset_mid();
    int le, lf;
    bit seen_ov;
    a = 8'hA5; b = 8'hA5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({in_ready_e, ov_e, busy_e, eq_e, in_ready_f, ov_f, busy_f, eq_f} !== 8'b1000_1000) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=%b",
               {in_ready_e, ov_e, busy_e, eq_e, in_ready_f, ov_f, busy_f, eq_f}, 8'b1000_1000);
    end
    seen_ov = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov_e || ov_f || busy_e || busy_f) seen_ov = 1'b1;
    end
    checks++;
    if (seen_ov !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_discard got activity=%0b exp=0", seen_ov);
    end
    do_op(8'hFF, 8'hFF, le, lf);
    checks++;
    if (le !== 9 || lf !== 9 || {eq_e, idx_e, eq_f, idx_f} !== 8'b1000_1000) begin
      failures++;
      $display("FAIL reset_mid_after got lat_e=%0d lat_f=%0d bits=%b exp 9 9 %b",
               le, lf, {eq_e, idx_e, eq_f, idx_f}, 8'b1000_1000);
    end
    do_release();
  endtask

  // Pairs differ at most in bit 7, so both instances scan all bits and stay in lockstep.
  task automatic test_back_to_back();
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic [3:0] xres [3];
    int p, r, t_prev;
    bit prev_busy;
    pa[0] = 8'h5A; pb[0] = 8'h5A; xres[0] = 4'b1000;
    pa[1] = 8'h80; pb[1] = 8'h00; xres[1] = 4'b0111;
    pa[2] = 8'h7F; pb[2] = 8'h7F; xres[2] = 4'b1000;
    p = 0; r = 0; t_prev = 0; prev_busy = 1'b0;
    a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 80 && r < 3; c++) begin
      @(posedge clk); #1;
      if (busy_f && !prev_busy) begin
        p++;
        if (p < 3) begin a = pa[p]; b = pb[p]; end
        else in_valid = 1'b0;
      end
      prev_busy = busy_f;
      if (ov_f) begin
        $display("b2b result %0d at cycle %0d eq_f=%0b idx_f=%0d eq_e=%0b idx_e=%0d",
                 r, c, eq_f, idx_f, eq_e, idx_e);
        checks++;
        if ({eq_f, idx_f} !== xres[r] || {ov_e, eq_e, idx_e} !== {1'b1, xres[r]}) begin
          failures++;
          $display("FAIL b2b_result%0d got f=%b e=%b exp f=%b e=%b", r,
                   {eq_f, idx_f}, {ov_e, eq_e, idx_e}, xres[r], {1'b1, xres[r]});
        end
        if (r > 0) begin
          checks++;
          if (c - t_prev !== 11) begin
            failures++;
            $display("FAIL b2b_spacing%0d got=%0d exp=11", r, c - t_prev);
          end
        end
        t_prev = c;
        r++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (r !== 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", r);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_pair("equal_a5", 8'hA5, 8'hA5, 9, 1'b1, 3'd0, 9, 1'b1, 3'd0);
    test_pair("early_bit4", 8'h10, 8'h00, 6, 1'b0, 3'd4, 9, 1'b0, 3'd4);
    test_pair("lowest_kept", 8'h81, 8'h00, 2, 1'b0, 3'd0, 9, 1'b0, 3'd0);
    test_pair("msb_only", 8'h80, 8'h00, 9, 1'b0, 3'd7, 9, 1'b0, 3'd7);
    test_pair("all_ones", 8'hFF, 8'hFF, 9, 1'b1, 3'd0, 9, 1'b1, 3'd0);
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
